// File: rtl/a7_bus_pkg.sv
// Shared constants, state encodings and frame helper for the A7 serial bus master.
// One link byte is start(1), flag, d7..d0, then two zero stop bits.
package a7_bus_pkg;
   localparam logic [7:0] OP_WRITE       = 8'h01;
   localparam logic [7:0] OP_READ        = 8'h02;
   localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;
   localparam int         FRAME_BITS     = 12;
   localparam int         REQ_BYTES      = 5;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

   function automatic logic [FRAME_BITS-1:0] frame_byte(input logic flag, input logic [7:0] data);
      return {1'b1, flag, data, 2'b00};
   endfunction
endpackage

// File: rtl/a7_serial_rx.sv
// Receive side of the one-wire link: registers serial_in, deframes flag+8 bits,
// checks both stop bits and keeps good-byte and framing-error counters.
module a7_serial_rx
   import a7_bus_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   output logic             byte_valid,
   output logic             byte_flag,
   output logic [7:0]       byte_data,
   output logic [CNT_W-1:0] bytes_seen,
   output logic [7:0]       frame_errs
);
   rx_state_t   rx_state, rx_state_nx;
   logic        rx_bit_p0;
   logic [3:0]  rx_cnt;
   logic [8:0]  rx_sh;
   logic        stop_err;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      rx_state_nx = rx_state;
      case (rx_state)
         RX_IDLE: if (rx_bit_p0) rx_state_nx = RX_DATA;
         RX_DATA: if (rx_cnt == 4'd8) rx_state_nx = RX_STOP;
         RX_STOP: if (rx_cnt == 4'd1) rx_state_nx = RX_IDLE;
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= RX_IDLE;
         rx_bit_p0  <= 1'b0;
         rx_cnt     <= 4'd0;
         rx_sh      <= 9'd0;
         stop_err   <= 1'b0;
         byte_valid <= 1'b0;
         byte_flag  <= 1'b0;
         byte_data  <= 8'd0;
         bytes_seen <= '0;
         frame_errs <= 8'd0;
      end else begin
         // stage p0: input register, the only place serial_in is sampled
         rx_bit_p0  <= serial_in;
         rx_state   <= rx_state_nx;
         byte_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt   <= 4'd0;
               stop_err <= 1'b0;
            end
            RX_DATA: begin
               rx_sh  <= {rx_sh[7:0], rx_bit_p0};
               rx_cnt <= (rx_cnt == 4'd8) ? 4'd0 : rx_cnt + 4'd1;
            end
            RX_STOP: begin
               if (rx_cnt == 4'd0) begin
                  stop_err <= rx_bit_p0;
                  rx_cnt   <= 4'd1;
               end else begin
                  rx_cnt <= 4'd0;
                  if (stop_err | rx_bit_p0) begin
                     frame_errs <= sat_inc8(frame_errs);
                  end else begin
                     byte_valid <= 1'b1;
                     byte_flag  <= rx_sh[8];
                     byte_data  <= rx_sh[7:0];
                     bytes_seen <= bytes_seen + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/a7_bus_master.sv
// Serialises one register read/write as five link bytes, then collects the
// slave's reply bytes until a flagged byte arrives or the reply times out.
module a7_bus_master
   import a7_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wr,
   input  logic [15:0]      req_addr,
   input  logic [15:0]      req_wrdata,
   output logic             rsp_valid,
   output logic [15:0]      rsp_rddata,
   output logic [7:0]       rsp_status,
   output logic             rsp_timeout,
   output logic             serial_out,
   input  logic             serial_in,
   output logic             busy,
   output logic [CNT_W-1:0] bytes_sent,
   output logic [CNT_W-1:0] bytes_seen,
   output logic [7:0]       frame_errs
);
   localparam int TX_BITS = FRAME_BITS * REQ_BYTES;
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state, state_nx;
   logic [TX_BITS-1:0] tx_sr;
   logic [3:0]         bit_idx;
   logic [2:0]         byte_idx;
   logic [23:0]        acc;
   logic               flag_seen;
   logic [TW-1:0]      tcnt;
   logic               ready_q;
   logic               rx_valid, rx_flag;
   logic [7:0]         rx_data;
   logic               accept, last_bit, collect, flag_hit, expire;
   logic [7:0]         d_hi, d_lo;

   a7_serial_rx #(.CNT_W(CNT_W)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .byte_valid (rx_valid),
      .byte_flag  (rx_flag),
      .byte_data  (rx_data),
      .bytes_seen (bytes_seen),
      .frame_errs (frame_errs)
   );

   assign accept   = req_valid & ready_q;
   assign last_bit = (state == SEND) && (byte_idx == 3'(REQ_BYTES - 1)) &&
                     (bit_idx == 4'(FRAME_BITS - 1));
   // once a flagged byte is latched, later bytes must not disturb the reply
   assign collect  = ((state == SEND) || (state == WAIT)) && rx_valid && !flag_seen;
   assign flag_hit = collect && rx_flag;
   assign expire   = (state == WAIT) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign d_hi     = req_wr ? req_wrdata[15:8] : 8'h00;
   assign d_lo     = req_wr ? req_wrdata[7:0]  : 8'h00;

   assign serial_out = tx_sr[TX_BITS-1];
   assign req_ready  = ready_q;
   assign busy       = (state != IDLE);
   assign rsp_valid  = (state == RESP);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = SEND;
         SEND: if (last_bit) state_nx = (flag_seen | flag_hit) ? RESP : WAIT;
         WAIT: if (flag_seen | flag_hit | expire) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr       <= '0;
         bit_idx     <= 4'd0;
         byte_idx    <= 3'd0;
         bytes_sent  <= '0;
         acc         <= 24'd0;
         flag_seen   <= 1'b0;
         tcnt        <= '0;
         ready_q     <= 1'b0;
         rsp_rddata  <= 16'd0;
         rsp_status  <= 8'd0;
         rsp_timeout <= 1'b0;
      end else begin
         ready_q <= (state_nx == IDLE);
         tcnt    <= (state == WAIT) ? tcnt + TW'(1) : '0;
         if (accept) begin
            tx_sr      <= {frame_byte(1'b0, req_addr[15:8]), frame_byte(1'b0, req_addr[7:0]),
                           frame_byte(1'b0, d_hi), frame_byte(1'b0, d_lo),
                           frame_byte(1'b1, req_wr ? OP_WRITE : OP_READ)};
            bit_idx    <= 4'd0;
            byte_idx   <= 3'd0;
            bytes_sent <= bytes_sent + CNT_W'(1);
            acc        <= 24'd0;
            flag_seen  <= 1'b0;
         end else if (state == SEND) begin
            tx_sr <= tx_sr << 1;
            if (bit_idx == 4'(FRAME_BITS - 1)) begin
               bit_idx  <= 4'd0;
               byte_idx <= byte_idx + 3'd1;
               if (!last_bit) bytes_sent <= bytes_sent + CNT_W'(1);
            end else begin
               bit_idx <= bit_idx + 4'd1;
            end
         end
         if (collect) begin
            acc <= {acc[15:0], rx_data};
            if (rx_flag) flag_seen <= 1'b1;
         end
         // results are published on the edge into RESP and held until the next one
         if ((state != RESP) && (state_nx == RESP)) begin
            if (flag_seen) begin
               rsp_status  <= acc[7:0];
               rsp_rddata  <= acc[23:8];
               rsp_timeout <= 1'b0;
            end else if (flag_hit) begin
               rsp_status  <= rx_data;
               rsp_rddata  <= acc[15:0];
               rsp_timeout <= 1'b0;
            end else begin
               rsp_status  <= STATUS_TIMEOUT;
               rsp_rddata  <= 16'd0;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_a7_bus_master.sv
// Directed plus randomised bench for a7_bus_master with a slave-side link model
// and a transaction-level reference for frames, replies and counters.
module tb_a7_bus_master;
   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0, req_wr = 1'b0, serial_in = 1'b0;
   logic [15:0] req_addr = 16'd0, req_wrdata = 16'd0;
   logic        req_ready, rsp_valid, rsp_timeout, serial_out, busy;
   logic [15:0] rsp_rddata, bytes_sent, bytes_seen;
   logic [7:0]  rsp_status, frame_errs;

   a7_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .req_wrdata(req_wrdata),
      .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata), .rsp_status(rsp_status),
      .rsp_timeout(rsp_timeout), .serial_out(serial_out), .serial_in(serial_in),
      .busy(busy), .bytes_sent(bytes_sent), .bytes_seen(bytes_seen), .frame_errs(frame_errs)
   );

   always #5 clk = ~clk;

   typedef struct { logic flag; logic [7:0] data; logic [1:0] stops; } rbyte_t;

   int          tests = 0, fails = 0;
   int          exp_sent = 0, exp_seen = 0, exp_ferr = 0;
   rbyte_t      rq[$];
   logic        rx_bits[$];
   logic [59:0] tx_got;
   logic        nx_wr;
   logic [15:0] nx_addr, nx_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [59:0] model_frame(input logic wr, input logic [15:0] a, input logic [15:0] d);
      logic [7:0]  b [5];
      logic [59:0] f;
      b[0] = a[15:8];
      b[1] = a[7:0];
      b[2] = wr ? d[15:8] : 8'h00;
      b[3] = wr ? d[7:0]  : 8'h00;
      b[4] = wr ? 8'h01 : 8'h02;
      f = '0;
      for (int i = 0; i < 5; i++) f = {f[47:0], 1'b1, (i == 4), b[i], 2'b00};
      return f;
   endfunction

   task automatic push_bits(input rbyte_t b);
      rx_bits.push_back(1'b1);
      rx_bits.push_back(b.flag);
      for (int k = 7; k >= 0; k--) rx_bits.push_back(b.data[k]);
      rx_bits.push_back(b.stops[1]);
      rx_bits.push_back(b.stops[0]);
   endtask

   // Reply semantics: drop bad-stop bytes, first flagged good byte ends the reply,
   // read data is the two good bytes preceding it (zero where absent).
   task automatic model_rsp(output logic [15:0] rd, output logic [7:0] st, output logic to);
      logic [7:0] p1, p2;
      p1 = 8'h00; p2 = 8'h00; rd = 16'h0000; st = 8'hFF; to = 1'b1;
      foreach (rq[i]) begin
         if (rq[i].stops != 2'b00) begin
            if (exp_ferr < 255) exp_ferr++;
         end else begin
            exp_seen++;
            if (rq[i].flag) begin
               st = rq[i].data; rd = {p2, p1}; to = 1'b0;
               break;
            end
            p2 = p1; p1 = rq[i].data;
         end
      end
   endtask

   task automatic start_req(input logic wr, input logic [15:0] a, input logic [15:0] d);
      int n;
      req_wr = wr; req_addr = a; req_wrdata = d; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      chk("req_ready_wait", req_ready, 1);
      exp_sent += 5;
   endtask

   task automatic do_txn(input string nm, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic hold);
      logic [15:0] e_rd;
      logic [7:0]  e_st;
      logic        e_to, found;
      int          c;
      start_req(wr, a, d);
      for (int k = 0; k < 60; k++) begin
         tick();
         if (k == 0) begin
            chk({nm, "_busy"}, busy, 1);
            chk({nm, "_ready_low"}, req_ready, 0);
            if (!hold) req_valid = 1'b0;
         end
         tx_got = {tx_got[58:0], serial_out};
      end
      chk({nm, "_txframe"}, tx_got, model_frame(wr, a, d));
      model_rsp(e_rd, e_st, e_to);
      foreach (rq[i]) push_bits(rq[i]);
      c = 0; found = 1'b0;
      while (c < TO + 100 && !found) begin
         tick();
         c++;
         if (rsp_valid) found = 1'b1;
         else serial_in = (rx_bits.size() > 0) ? rx_bits.pop_front() : 1'b0;
      end
      serial_in = 1'b0;
      chk({nm, "_rsp_seen"}, found, 1);
      chk({nm, "_rddata"}, rsp_rddata, e_rd);
      chk({nm, "_status"}, rsp_status, e_st);
      chk({nm, "_timeout"}, rsp_timeout, e_to);
      chk({nm, "_bytes_sent"}, bytes_sent, exp_sent[15:0]);
      chk({nm, "_bytes_seen"}, bytes_seen, exp_seen[15:0]);
      chk({nm, "_frame_errs"}, frame_errs, exp_ferr[7:0]);
      if (e_to) chk({nm, "_to_latency"}, 64'(c), 64'(TO + 1));
      if (hold) begin req_wr = nx_wr; req_addr = nx_addr; req_wrdata = nx_data; end
      tick();
      chk({nm, "_rsp_pulse"}, rsp_valid, 0);
      chk({nm, "_ready_after"}, req_ready, 1);
      chk({nm, "_status_held"}, rsp_status, e_st);
      rq.delete();
      rx_bits.delete();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_rsp;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_serial_out", serial_out, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_counters", {bytes_sent, bytes_seen, frame_errs}, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", req_ready, 1);

      // write 0x0003 <= 0x1234
      rq.push_back('{1'b0, 8'h12, 2'b00});
      rq.push_back('{1'b0, 8'h34, 2'b00});
      rq.push_back('{1'b1, 8'h00, 2'b00});
      do_txn("wr", 1'b1, 16'h0003, 16'h1234, 1'b0);
      chk("wr_first_byte_bits", tx_got[59:48], 12'h800);
      chk("wr_last_byte_bits", tx_got[11:0], 12'hC04);

      // read 0x0001 returns 0xBEEF
      rq.push_back('{1'b0, 8'hBE, 2'b00});
      rq.push_back('{1'b0, 8'hEF, 2'b00});
      rq.push_back('{1'b1, 8'h00, 2'b00});
      do_txn("rd", 1'b0, 16'h0001, 16'hA5A5, 1'b0);

      do_txn("silent", 1'b0, 16'h0042, 16'h0000, 1'b0);

      rq.push_back('{1'b0, 8'hAA, 2'b00});
      rq.push_back('{1'b0, 8'h55, 2'b10});
      rq.push_back('{1'b1, 8'h07, 2'b00});
      do_txn("ferr", 1'b0, 16'h0100, 16'h0000, 1'b0);

      // reset in the middle of a transmitted frame
      start_req(1'b1, 16'h00A0, 16'h5555);
      tick();
      req_valid = 1'b0;
      repeat (29) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_serial_out", serial_out, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_counters", {bytes_sent, bytes_seen, frame_errs}, 0);
      exp_sent = 0; exp_seen = 0; exp_ferr = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_ready", req_ready, 1);
      seen_rsp = 1'b0;
      repeat (80) begin tick(); if (rsp_valid) seen_rsp = 1'b1; end
      chk("midrst_no_rsp", seen_rsp, 0);
      rq.push_back('{1'b0, 8'hC3, 2'b00});
      rq.push_back('{1'b1, 8'h00, 2'b00});
      do_txn("after_rst", 1'b1, 16'h00A0, 16'h5555, 1'b0);

      // stray byte while idle, then two requests back to back
      push_bits('{1'b0, 8'h77, 2'b00});
      while (rx_bits.size() > 0) begin serial_in = rx_bits.pop_front(); tick(); end
      serial_in = 1'b0;
      repeat (16) tick();
      exp_seen++;
      chk("stray_seen", bytes_seen, exp_seen[15:0]);
      nx_wr = 1'b1; nx_addr = 16'h2222; nx_data = 16'h9ABC;
      rq.push_back('{1'b0, 8'h12, 2'b00});
      rq.push_back('{1'b1, 8'h5A, 2'b00});
      do_txn("b2b_a", 1'b0, 16'h1111, 16'h0000, 1'b1);
      rq.push_back('{1'b1, 8'h3C, 2'b00});
      do_txn("b2b_b", nx_wr, nx_addr, nx_data, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic        wr;
         logic [15:0] a, d;
         int          nb;
         wr = 1'($urandom_range(0, 1));
         a = 16'($urandom);
         d = 16'($urandom);
         nb = $urandom_range(0, 3);
         for (int j = 0; j < nb; j++) begin
            logic [1:0] st;
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rq.push_back('{1'b0, 8'($urandom), st});
         end
         rq.push_back('{1'b1, 8'($urandom), 2'b00});
         do_txn("rand", wr, a, d, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/a7_bus_master.md
Name: a7_bus_master

Overview:
- Serial bus-transaction engine on the Microzed PL side. It sits directly upstream of the one-wire link to the Spartan6/Artix7 bus FSM and directly downstream of the register-bus glue.
- It takes one read or write request, serialises it as five 9-bit "bytes" (flag + 8 data), and deserialises the slave's reply bytes. It returns read data and status, or reports a timeout.
- It replaces hand-poking bytes one at a time through a shift register.

Parameters:
TIMEOUT_CYCLES, 1024, clk cycles allowed from the last transmitted bit to the flagged reply byte.
CNT_W, 16, width of the bytes_sent/bytes_seen counters.

Ports:
clk  input  1  fabric clock (PS fclk0); the link bit rate is one bit per clk.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted on req_valid & req_ready.
req_wr  input  1  1 = write, 0 = read.
req_addr  input  16  target register address.
req_wrdata  input  16  write data; ignored for reads.
rsp_valid  output  1  one-cycle pulse when a transaction completes.
rsp_rddata  output  16  read data; held until the next rsp_valid.
rsp_status  output  8  slave status byte, or 8'hFF on timeout; held.
rsp_timeout  output  1  qualifies rsp_valid; held.
serial_out  output  1  link to the slave; idle level 0.
serial_in  input  1  link from the slave; idle level 0.
busy  output  1  high in any state other than IDLE.
bytes_sent  output  CNT_W  count of transmitted bytes; wraps.
bytes_seen  output  CNT_W  count of received good bytes; wraps.
frame_errs  output  8  count of received bytes with bad stop bits; saturates at 255.

Behaviour:
- Reset: all outputs are 0, state is IDLE, serial_out is 0 immediately (asynchronous), and the rx accumulator is cleared. Reset mid-frame aborts the transaction silently, with no rsp_valid.
- Frame format, one bit per clk, in this order:
  - start bit = 1;
  - flag bit;
  - d7..d0, MSB first;
  - two stop bits = 0.
  - Total 12 bit-times per byte. Consecutive tx bytes are back-to-back.
- Request bytes, in order:
  - {0, addr[15:8]}
  - {0, addr[7:0]}
  - {0, wrdata[15:8]}
  - {0, wrdata[7:0]}
  - {1, opcode}, where opcode is OP_WRITE = 8'h01 or OP_READ = 8'h02.
  - Read requests send 8'h00 in both data bytes.
- FSM transitions:
  - IDLE -> SEND on accept. The accept cycle is T; the first start bit appears on serial_out at T+1 and the last stop bit at T+60.
  - SEND -> WAIT after bit 60.
  - WAIT -> RESP when a flagged rx byte is received, or when the timeout counter reaches TIMEOUT_CYCLES.
  - RESP -> IDLE after one cycle.
- rsp_valid is asserted in RESP; req_ready returns high the cycle after.
- bytes_sent increments at each tx start bit.
- Rx path:
  - serial_in is registered once before use.
  - The rx FSM idles until a 1 is seen, then captures flag + 8 bits and checks the two stop bits.
  - Good stop bits: bytes_seen increments and the byte is delivered.
  - Bad stop bits: frame_errs increments, the byte is dropped, and rx returns to idle.
- Accumulator:
  - 24-bit shift {acc[15:0], byte}, cleared on request accept.
  - Bytes are collected in SEND and WAIT; bytes arriving in IDLE are counted but discarded.
- Flagged rx byte in WAIT or SEND:
  - rsp_status = that byte;
  - rsp_rddata = {byte n-2, byte n-1}, with zeros where fewer bytes were received;
  - rsp_timeout = 0.
  - A flagged byte received during SEND is latched, and RESP follows the last tx bit.
- Timeout: the counter starts at 0 on entry to WAIT. On expiry, rsp_status = 8'hFF, rsp_rddata = 0, rsp_timeout = 1.
- A flagged byte completing in the same cycle the timeout expires wins (no timeout).
- req_valid while busy is ignored; there is no queueing.

Decomposition:
- Package a7_bus_pkg:
  - OP_WRITE, OP_READ;
  - STATUS_TIMEOUT = 8'hFF;
  - FRAME_BITS = 12;
  - REQ_BYTES = 5;
  - state enum {IDLE, SEND, WAIT, RESP}.
- Sub-module a7_serial_rx: input register, rx FSM, stop-bit check, byte/flag/valid outputs, and the bytes_seen/frame_errs counters. Tx shifter and master FSM stay in the top.

Test Plan:
- Write 0x0003 <= 0x1234, slave model replies {0,12},{0,34},{1,00}:
  - serial_out bits T+1..T+12 are 1,0,0,0,0,0,0,0,0,0,0,0;
  - the last byte carries flag 1 and 0x01;
  - rsp_status = 0x00, rsp_timeout = 0, bytes_sent = 5, bytes_seen = 3.
- Read 0x0001, slave replies {0,BE},{0,EF},{1,00} -> rsp_rddata = 0xBEEF, rsp_status = 0x00; tx data bytes are 0x00.
- Read with a silent slave -> rsp_valid exactly TIMEOUT_CYCLES+1 cycles after the last tx bit, with rsp_status = 0xFF, rsp_timeout = 1, rsp_rddata = 0.
- Rx byte with stop bits 1,0 mid-reply -> frame_errs = 1, the byte is dropped, and the following flagged byte still completes the transaction.
- rst_n low at T+30 -> serial_out = 0 the same cycle, no rsp_valid, and req_ready = 1 after release; a new request then completes normally.
- Stray byte in IDLE, then back-to-back requests held on req_valid -> bytes_seen increments, the response is unaffected, and the second request is accepted exactly 1 cycle after rsp_valid.
